led_pattern_monitor: RTL
========================

# led_pattern_monitor

Static-side observer that reads the 4-bit LED outputs of the count and shift reconfigurable modules and decodes which behaviour is loaded: count up, count down, rotate left or rotate right. It samples both buses on an internal prescaled tick, classifies each step, and confirms a direction only after a run of consistent steps. It reports illegal steps so a bench or status LED can detect a bad or partially loaded RM. It sits in the top-level static region beside the RM instances, on the same clock.

## Interface
- DIV_W, 23: prescaler width; one sample tick every 2^DIV_W clk cycles.
- CONFIRM, 3: consecutive identical legal step events needed to confirm a class (range 1..15).
- clk  in  1  system clock; all inputs are synchronous to it.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear; returns all state to reset values.
- hold  in  1  when 1, ignore ticks and invalidate the previous sample (asserted during partial reconfiguration).
- count_in  in  4  count RM LED bus.
- shift_in  in  4  shift RM LED bus.
- count_dir  out  2  00 unknown, 01 up, 10 down, 11 stalled.
- shift_dir  out  2  00 unknown, 01 left, 10 right, 11 static.
- dir_change  out  1  one-cycle pulse when either count_dir or shift_dir changes value.
- err_count  out  8  saturating count of illegal steps on both channels.

## Operation
- Prescaler: DIV_W-bit up-counter that wraps. tick=1 on the cycle the counter equals all-ones.
- Previous-sample registers: prev_count, prev_shift, have_prev. On a tick with have_prev=0, load the current samples and set have_prev=1. No classification on that tick.
- Count step on a tick with have_prev=1, with d = (count_in − prev_count) mod 16:
  - d=1: UP.
  - d=15: DOWN.
  - d=0: STALL.
  - any other d: ILLEGAL.
- Shift step, checked in this priority order:
  - shift_in==prev_shift: STATIC.
  - rotl(prev_shift) equals rotr(prev_shift) and shift_in matches them (patterns 0101/1010): AMBIGUOUS. No event, and run state is unchanged.
  - shift_in==rotl(prev_shift,1): LEFT.
  - shift_in==rotr(prev_shift,1): RIGHT.
  - otherwise: ILLEGAL.
- Per-channel confirm FSM, with registers cand (class) and run (4 bits):
  - Legal event equal to cand: run increments, saturating at CONFIRM.
  - Legal event differing from cand: cand=event, run=1.
  - Confirmation: when run reaches CONFIRM and the output differs from cand, the output is set to cand.
  - ILLEGAL: run=0, cand=none. The output is retained (hysteresis). err_count increments, saturating at 255.
  - Both channels ILLEGAL on the same tick: err_count += 2, still saturating at 255.
- prev registers load the current samples on every tick where have_prev=1, regardless of the step class.
- hold=1: ticks are ignored and have_prev=0 is forced. The prescaler keeps running. cand, run, outputs and err_count are retained.
- clear=1: same effect as reset, including the prescaler. clear has priority over tick and hold.

## Timing
- Reset and clear values: count_dir=00, shift_dir=00, dir_change=0, err_count=0, prescaler=0, have_prev=0, run=0, cand=none.
- Sampling: inputs are sampled on the tick cycle. All outputs are registered and change on the clock edge that ends the tick cycle (1-cycle latency from the tick).
- dir_change is high for exactly the one cycle in which the new direction value is first visible.
- Minimum time to confirmation after reset or hold release: (CONFIRM+1) ticks.
- First tick after reset occurs 2^DIV_W − 1 cycles after rst_n deassertion.
- Asynchronous reset mid-run: all state returns to reset values immediately. No dir_change pulse is generated.

## Test plan
All scenarios use DIV_W=2 (tick every 4 cycles) and CONFIRM=3.
- Count 0,1,2,3 on successive ticks -> count_dir=01 one cycle after the 4th tick; single dir_change pulse; err_count=0.
- Count 14,15,0,1 -> count_dir=01 (wrap is legal). Then 0,15,14 -> stays 01 after 2 DOWN events, becomes 10 after the 3rd, with one dir_change pulse.
- Shift 0001,0010,0100,1000 -> shift_dir=01. Then 0100,0010,0001 -> shift_dir=10. Insert 0101->1010 mid-run -> no event, and the run continues.
- Count 3->7 jump -> err_count=1, count_dir retained, run reset (3 more UP events are needed to reconfirm). Force 300 illegal steps -> err_count=255.
- Confirmed up, hold=1 for 20 cycles with count_in randomised, then release -> err_count unchanged, first tick only reloads, count_dir stays 01.
- clear asserted on a tick cycle -> tick ignored, all outputs reset. rst_n pulsed mid-run -> outputs reset asynchronously with no dir_change pulse.

Source files
------------

// File: rtl/led_pattern_monitor.sv
// led_pattern_monitor
// Static-region observer that decodes which behaviour the count and shift
// reconfigurable modules are running, based only on their 4-bit LED buses.
// Both buses are sampled on a prescaled tick. Each step is classified, and a
// direction is confirmed only after a run of identical legal steps. Illegal
// steps are counted so that a bad or half-loaded RM shows up.
`timescale 1ns/1ps

module led_pattern_monitor #(
    parameter int DIV_W   = 23,
    parameter int CONFIRM = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       hold,
    input  logic [3:0] count_in,
    input  logic [3:0] shift_in,
    output logic [1:0] count_dir,
    output logic [1:0] shift_dir,
    output logic       dir_change,
    output logic [7:0] err_count
);

    // Step classification for one tick. POS/NEG/STILL are the legal events:
    // up/down/stall on the count channel, and left/right/static on the
    // shift channel. EV_NONE covers "no classification" and the ambiguous
    // 0101/1010 shift case.
    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_POS     = 3'd1,
        EV_NEG     = 3'd2,
        EV_STILL   = 3'd3,
        EV_ILLEGAL = 3'd4
    } step_ev_t;

    // Candidate class of the confirm FSM. Its encoding equals the direction
    // output code, so a confirmed candidate is copied to the output directly.
    typedef enum logic [1:0] {
        CAND_NONE  = 2'b00,
        CAND_POS   = 2'b01,
        CAND_NEG   = 2'b10,
        CAND_STILL = 2'b11
    } cand_t;

    // Complete state of one channel's confirm FSM.
    typedef struct packed {
        cand_t      cand;
        logic [3:0] run;
        logic [1:0] dir;
    } chan_t;

    localparam logic [3:0] CONFIRM_C = 4'(CONFIRM);
    localparam chan_t      CH_RESET  = '{cand: CAND_NONE, run: 4'd0, dir: 2'b00};

    // Count channel: the step is the modulo-16 difference to the previous sample.
    function automatic step_ev_t classify_count(input logic [3:0] cur, input logic [3:0] prev);
        logic [3:0] d;
        step_ev_t   ev;
        d = cur - prev;
        case (d)
            4'd1:    ev = EV_POS;
            4'd15:   ev = EV_NEG;
            4'd0:    ev = EV_STILL;
            default: ev = EV_ILLEGAL;
        endcase
        return ev;
    endfunction

    // Shift channel: a single-position rotate in either direction. For
    // 0101/1010, left and right rotation are indistinguishable, so such a
    // step carries no direction information.
    function automatic step_ev_t classify_shift(input logic [3:0] cur, input logic [3:0] prev);
        logic [3:0] rl;
        logic [3:0] rr;
        step_ev_t   ev;
        rl = {prev[2:0], prev[3]};
        rr = {prev[0], prev[3:1]};
        if (cur == prev) begin
            ev = EV_STILL;
        end else if ((rl == rr) && (cur == rl)) begin
            ev = EV_NONE;
        end else if (cur == rl) begin
            ev = EV_POS;
        end else if (cur == rr) begin
            ev = EV_NEG;
        end else begin
            ev = EV_ILLEGAL;
        end
        return ev;
    endfunction

    // Map a legal event to the candidate class it votes for.
    function automatic cand_t ev_to_cand(input step_ev_t ev);
        cand_t c;
        case (ev)
            EV_POS:   c = CAND_POS;
            EV_NEG:   c = CAND_NEG;
            EV_STILL: c = CAND_STILL;
            default:  c = CAND_NONE;
        endcase
        return c;
    endfunction

    // One confirm-FSM step. A run of CONFIRM identical legal events
    // publishes the candidate. An illegal step drops the candidate but
    // keeps the published direction, so a glitch does not blank the status.
    function automatic chan_t confirm_step(input chan_t cur, input step_ev_t ev);
        chan_t nxt;
        nxt = cur;
        case (ev)
            EV_POS, EV_NEG, EV_STILL: begin
                if (cur.cand == ev_to_cand(ev)) begin
                    if (cur.run >= CONFIRM_C) begin
                        nxt.run = CONFIRM_C;
                    end else begin
                        nxt.run = cur.run + 4'd1;
                    end
                end else begin
                    nxt.cand = ev_to_cand(ev);
                    nxt.run  = 4'd1;
                end
                if ((nxt.run == CONFIRM_C) && (cur.dir != nxt.cand)) begin
                    nxt.dir = nxt.cand;
                end else begin
                    nxt.dir = cur.dir;
                end
            end
            EV_ILLEGAL: begin
                nxt.cand = CAND_NONE;
                nxt.run  = 4'd0;
            end
            default: begin
                nxt = cur;
            end
        endcase
        return nxt;
    endfunction

    logic [DIV_W-1:0] r_presc;
    logic [3:0]       r_prev_count;
    logic [3:0]       r_prev_shift;
    logic             r_have_prev;
    chan_t            r_count_ch;
    chan_t            r_shift_ch;
    logic             r_dir_change;
    logic [7:0]       r_err_count;

    logic             w_tick;
    logic             w_classify;
    step_ev_t         w_count_ev;
    step_ev_t         w_shift_ev;
    chan_t            w_count_ch_nxt;
    chan_t            w_shift_ch_nxt;
    logic [1:0]       w_n_illegal;
    logic [8:0]       w_err_sum;
    logic [7:0]       w_err_nxt;
    logic             w_dir_change_nxt;

    assign w_tick     = &r_presc;
    assign w_classify = w_tick && !hold && r_have_prev;

    // Classify both channels on a tick that has a valid previous sample.
    always_comb begin
        w_count_ev = EV_NONE;
        w_shift_ev = EV_NONE;
        if (w_classify) begin
            w_count_ev = classify_count(count_in, r_prev_count);
            w_shift_ev = classify_shift(shift_in, r_prev_shift);
        end else begin
            w_count_ev = EV_NONE;
            w_shift_ev = EV_NONE;
        end
    end

    // Next state of both confirm FSMs, and the direction-change flag.
    always_comb begin
        w_count_ch_nxt   = confirm_step(r_count_ch, w_count_ev);
        w_shift_ch_nxt   = confirm_step(r_shift_ch, w_shift_ev);
        w_dir_change_nxt = (w_count_ch_nxt.dir != r_count_ch.dir) ||
                           (w_shift_ch_nxt.dir != r_shift_ch.dir);
    end

    // Saturating error accumulation. Both channels can add in the same tick.
    always_comb begin
        w_n_illegal = {1'b0, (w_count_ev == EV_ILLEGAL)} + {1'b0, (w_shift_ev == EV_ILLEGAL)};
        w_err_sum   = {1'b0, r_err_count} + {7'd0, w_n_illegal};
        if (w_err_sum > 9'd255) begin
            w_err_nxt = 8'd255;
        end else begin
            w_err_nxt = w_err_sum[7:0];
        end
    end

    // Free-running prescaler. It keeps counting through hold and restarts on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (clear) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Previous-sample registers. hold invalidates them so that the first
    // tick after a reconfiguration only reloads them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_count <= 4'd0;
            r_prev_shift <= 4'd0;
            r_have_prev  <= 1'b0;
        end else if (clear) begin
            r_prev_count <= 4'd0;
            r_prev_shift <= 4'd0;
            r_have_prev  <= 1'b0;
        end else if (hold) begin
            r_have_prev  <= 1'b0;
        end else if (w_tick) begin
            r_prev_count <= count_in;
            r_prev_shift <= shift_in;
            r_have_prev  <= 1'b1;
        end else begin
            r_have_prev  <= r_have_prev;
        end
    end

    // Confirm-FSM state, error counter and direction-change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_ch   <= CH_RESET;
            r_shift_ch   <= CH_RESET;
            r_err_count  <= 8'd0;
            r_dir_change <= 1'b0;
        end else if (clear) begin
            r_count_ch   <= CH_RESET;
            r_shift_ch   <= CH_RESET;
            r_err_count  <= 8'd0;
            r_dir_change <= 1'b0;
        end else begin
            r_count_ch   <= w_count_ch_nxt;
            r_shift_ch   <= w_shift_ch_nxt;
            r_err_count  <= w_err_nxt;
            r_dir_change <= w_dir_change_nxt;
        end
    end

    assign count_dir  = r_count_ch.dir;
    assign shift_dir  = r_shift_ch.dir;
    assign dir_change = r_dir_change;
    assign err_count  = r_err_count;

endmodule
